// File: rtl/exp_stream_pkg.sv
// exp_stream_pkg: shared sizes, counter widths and block type for the exponent stream
package exp_stream_pkg;
  localparam int REGISTER_SIZE = 32;
  localparam int BITS_IN_NUM = 2048;
  localparam int NUM_BLOCKS_PER_SQUARE = 2 * BITS_IN_NUM / REGISTER_SIZE;
  localparam int NUM_SQUARES = BITS_IN_NUM;
  localparam int BLOCK_CTR_W = $clog2(NUM_BLOCKS_PER_SQUARE);
  localparam int SQUARE_CTR_W = $clog2(NUM_SQUARES);
  typedef logic [REGISTER_SIZE-1:0] block_t;
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/exponent_word_buffer.sv
// exponent_word_buffer: two-entry cur/nxt exponent word buffer with load, retire and consume pulse
module exponent_word_buffer
  import exp_stream_pkg::*;
#(
  parameter int W = exp_stream_pkg::REGISTER_SIZE
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [W-1:0] word_i,
  input  logic         valid_i,
  input  logic         retire_i,
  output logic [W-1:0] cur_o,
  output logic [W-1:0] nxt_o,
  output logic         cur_full_o,
  output logic         nxt_full_o,
  output logic         consumed_o
);
  logic [W-1:0] cur_q, cur_d, nxt_q, nxt_d, cur_r;
  logic cur_full_q, cur_full_d, nxt_full_q, nxt_full_d, cur_full_r, nxt_full_r;
  // retire first, then drop an accepted word into the lowest empty slot
  always_comb begin
    consumed_o = valid_i & ~rst_in & ~(cur_full_q & nxt_full_q);
    cur_r = retire_i ? nxt_q : cur_q;
    cur_full_r = retire_i ? nxt_full_q : cur_full_q;
    nxt_full_r = retire_i ? 1'b0 : nxt_full_q;
    cur_d = (consumed_o & ~cur_full_r) ? word_i : cur_r;
    cur_full_d = cur_full_r | consumed_o;
    nxt_d = (consumed_o & cur_full_r) ? word_i : nxt_q;
    nxt_full_d = nxt_full_r | (consumed_o & cur_full_r);
  end
  // buffer state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cur_q <= '0;
      nxt_q <= '0;
      cur_full_q <= 1'b0;
      nxt_full_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      cur_full_q <= cur_full_d;
      nxt_full_q <= nxt_full_d;
    end
  end
  assign cur_o = cur_q;
  assign nxt_o = nxt_q;
  assign cur_full_o = cur_full_q;
  assign nxt_full_o = nxt_full_q;
endmodule

// File: rtl/square_exponent_selector.sv
// square_exponent_selector: forwards squares whose exponent bit is set; SQUARE_SELECTOR_COUNT_EN adds selected_count_out
module square_exponent_selector
  import exp_stream_pkg::*;
#(
  parameter int REGISTER_SIZE = exp_stream_pkg::REGISTER_SIZE,
  parameter int BITS_IN_NUM = exp_stream_pkg::BITS_IN_NUM
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] square_block_in,
  input  logic                     square_valid_in,
  input  logic [REGISTER_SIZE-1:0] exponent_block_in,
  input  logic                     exponent_valid_in,
  output logic                     consumed_exponent_out,
  output logic [REGISTER_SIZE-1:0] selected_block_out,
  output logic                     selected_valid_out,
  output logic                     selected_first_out,
  output logic                     selected_last_out,
  output logic                     done_out,
  output logic                     none_selected_out,
`ifdef SQUARE_SELECTOR_COUNT_EN
  output logic [$clog2(BITS_IN_NUM+1)-1:0] selected_count_out,
`endif
  output logic                     underrun_out
);
  localparam int NUM_BLOCKS_PER_SQUARE = 2 * BITS_IN_NUM / REGISTER_SIZE;
  localparam int NUM_SQUARES = BITS_IN_NUM;
  localparam int BW = ctr_w(NUM_BLOCKS_PER_SQUARE);
  localparam int SW = ctr_w(NUM_SQUARES);
  localparam int IW = ctr_w(REGISTER_SIZE);
  localparam int LAST_WORD_SQ = NUM_SQUARES - REGISTER_SIZE;
  logic [BW-1:0] block_ctr_q, block_ctr_d;
  logic [SW-1:0] square_ctr_q, square_ctr_d;
  logic [IW-1:0] bit_idx;
  logic [REGISTER_SIZE-1:0] cur_word, nxt_word, above, block_q, block_d;
  logic cur_full, nxt_full, retire;
  logic blk0, last_blk, last_sq, last_word, sel_now, take, no_higher, end_run;
  logic sel_q, sel_d, any_sel_q, any_sel_d, valid_q, valid_d, first_q, first_d;
  logic last_q, last_d, done_q, done_d, none_q, none_d, underrun_q, underrun_d;
  exponent_word_buffer #(.W(REGISTER_SIZE)) u_buf (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .word_i(exponent_block_in),
    .valid_i(exponent_valid_in),
    .retire_i(retire),
    .cur_o(cur_word),
    .nxt_o(nxt_word),
    .cur_full_o(cur_full),
    .nxt_full_o(nxt_full),
    .consumed_o(consumed_exponent_out)
  );
  // position tracking, selection and lookahead for the final selected square
  always_comb begin
    bit_idx = square_ctr_q[IW-1:0];
    blk0 = block_ctr_q == '0;
    last_blk = block_ctr_q == BW'(NUM_BLOCKS_PER_SQUARE - 1);
    last_sq = square_ctr_q == SW'(NUM_SQUARES - 1);
    last_word = square_ctr_q >= SW'(LAST_WORD_SQ);
    sel_now = blk0 ? (cur_full & cur_word[bit_idx]) : sel_q;
    take = square_valid_in & sel_now;
    above = (cur_word >> bit_idx) >> 1;
    no_higher = (above == '0) & (last_word | ~nxt_full | (nxt_word == '0));
    end_run = square_valid_in & last_blk & last_sq;
    retire = square_valid_in & last_blk & (bit_idx == IW'(REGISTER_SIZE - 1));
    block_ctr_d = square_valid_in ? (last_blk ? '0 : block_ctr_q + 1'b1) : block_ctr_q;
    square_ctr_d = (square_valid_in & last_blk) ? (last_sq ? '0 : square_ctr_q + 1'b1) : square_ctr_q;
    sel_d = square_valid_in ? sel_now : sel_q;
    any_sel_d = end_run ? 1'b0 : (any_sel_q | take);
    block_d = square_block_in;
    valid_d = take;
    first_d = take & ~any_sel_q;
    last_d = take & last_blk & no_higher;
    done_d = end_run;
    none_d = end_run & ~(any_sel_q | take);
    underrun_d = underrun_q | (square_valid_in & blk0 & ~cur_full);
  end
  // counters, selection state and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      block_ctr_q <= '0;
      square_ctr_q <= '0;
      sel_q <= 1'b0;
      any_sel_q <= 1'b0;
      block_q <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      none_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      block_ctr_q <= block_ctr_d;
      square_ctr_q <= square_ctr_d;
      sel_q <= sel_d;
      any_sel_q <= any_sel_d;
      block_q <= block_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q <= last_d;
      done_q <= done_d;
      none_q <= none_d;
      underrun_q <= underrun_d;
    end
  end
  assign selected_block_out = block_q;
  assign selected_valid_out = valid_q;
  assign selected_first_out = first_q;
  assign selected_last_out = last_q;
  assign done_out = done_q;
  assign none_selected_out = none_q;
  assign underrun_out = underrun_q;
`ifdef SQUARE_SELECTOR_COUNT_EN
  localparam int CW = $clog2(BITS_IN_NUM + 1);
  logic [CW-1:0] count_q, count_d;
  // count selected squares; value survives the done cycle, then restarts
  always_comb begin
    count_d = (done_q ? '0 : count_q) + CW'(take & last_blk);
  end
  // selected square counter register
  always_ff @(posedge clk_in) begin
    if (rst_in) count_q <= '0;
    else count_q <= count_d;
  end
  assign selected_count_out = count_q;
`endif
endmodule

// File: tb/tb_square_exponent_selector.sv
// tb_square_exponent_selector: table-driven plus scoreboard bench for square_exponent_selector
module tb_square_exponent_selector;
  localparam int RS = 8;
  localparam int BN = 16;
  localparam int NBLK = 4;
  localparam int NSQ = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_in = 1'b1;
  logic [7:0] square_block_in = '0;
  logic square_valid_in = 1'b0;
  logic [7:0] exponent_block_in = '0;
  logic exponent_valid_in = 1'b0;
  logic consumed_exponent_out, selected_valid_out, selected_first_out, selected_last_out;
  logic done_out, none_selected_out, underrun_out;
  logic [7:0] selected_block_out;
`ifdef SQUARE_SELECTOR_COUNT_EN
  logic [4:0] selected_count_out;
`endif
  square_exponent_selector #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .square_block_in(square_block_in),
    .square_valid_in(square_valid_in),
    .exponent_block_in(exponent_block_in),
    .exponent_valid_in(exponent_valid_in),
    .consumed_exponent_out(consumed_exponent_out),
    .selected_block_out(selected_block_out),
    .selected_valid_out(selected_valid_out),
    .selected_first_out(selected_first_out),
    .selected_last_out(selected_last_out),
    .done_out(done_out),
    .none_selected_out(none_selected_out),
`ifdef SQUARE_SELECTOR_COUNT_EN
    .selected_count_out(selected_count_out),
`endif
    .underrun_out(underrun_out)
  );
  typedef struct packed {
    logic [7:0] data;
    logic first;
    logic last;
  } exp_t;
  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int gmax;
    logic none;
    int cnt;
    int fwd;
  } vec_t;
  exp_t sbq[$];
  logic [7:0] eq[$];
  int n_cmp = 0, n_bad = 0, cons_cnt = 0, fwd_cnt = 0;
  logic [15:0] m_exp = '0;
  int mblk = 0, msq = 0, lo = -1, hi = -1;
  bit done_exp = 0, none_exp = 0, run_none = 0;
  int cnt_exp = 0, run_cnt = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic set_exp(input logic [15:0] e, input logic none, input int cnt);
    m_exp = e;
    run_none = none;
    run_cnt = cnt;
    lo = -1;
    hi = -1;
    for (int i = 0; i < NSQ; i++) if (e[i]) begin
      if (lo < 0) lo = i;
      hi = i;
    end
  endtask
  task automatic check_outputs();
    exp_t e;
    if (selected_valid_out) begin
      fwd_cnt++;
      if (sbq.size() == 0) chk("spurious_valid", {selected_block_out, selected_first_out, selected_last_out}, 32'h0);
      else begin
        e = sbq.pop_front();
        chk("block", {selected_block_out, selected_first_out, selected_last_out}, e);
      end
    end
    if (done_out || done_exp) begin
      chk("done", done_out, done_exp);
      if (done_exp) begin
        chk("none_selected", none_selected_out, none_exp);
`ifdef SQUARE_SELECTOR_COUNT_EN
        chk("count", selected_count_out, cnt_exp);
`endif
      end
      done_exp = 0;
    end
  endtask
  task automatic step(input bit v, input logic [7:0] b);
    @(negedge clk);
    check_outputs();
    square_valid_in = v;
    square_block_in = v ? b : 8'h00;
    exponent_valid_in = eq.size() > 0;
    exponent_block_in = (eq.size() > 0) ? eq[0] : 8'h00;
    #1;
    if (consumed_exponent_out) begin
      void'(eq.pop_front());
      cons_cnt++;
    end
    if (v) begin
      if (m_exp[msq]) sbq.push_back({b, 1'(msq == lo && mblk == 0), 1'(msq == hi && mblk == NBLK - 1)});
      if (mblk == NBLK - 1 && msq == NSQ - 1) begin
        done_exp = 1;
        none_exp = run_none;
        cnt_exp = run_cnt;
      end
      if (mblk == NBLK - 1) begin
        mblk = 0;
        msq = (msq == NSQ - 1) ? 0 : msq + 1;
      end else mblk++;
    end
  endtask
  task automatic run(input int gmax);
    for (int s = 0; s < NSQ; s++)
      for (int k = 0; k < NBLK; k++) begin
        if (gmax > 0) repeat ($urandom_range(0, gmax)) step(0, 8'h00);
        step(1, 8'(s * NBLK + k));
      end
  endtask
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst_in = 1;
    square_valid_in = 0;
    exponent_valid_in = 0;
    square_block_in = 0;
    exponent_block_in = 0;
    @(negedge clk);
    chk("reset_state", {selected_block_out, selected_valid_out, selected_first_out, selected_last_out,
                        done_out, none_selected_out, underrun_out, consumed_exponent_out}, 32'h0);
    rst_in = 0;
    mblk = 0;
    msq = 0;
    sbq.delete();
    eq.delete();
    done_exp = 0;
    fwd_cnt = 0;
    cons_cnt = 0;
  endtask
  vec_t tbl[6];
  initial begin
    tbl[0] = '{8'h05, 8'h80, 0, 1'b0, 3, 12};
    tbl[1] = '{8'h00, 8'h00, 0, 1'b1, 0, 0};
    tbl[2] = '{8'hFF, 8'hFF, 3, 1'b0, 16, 64};
    tbl[3] = '{8'h01, 8'h00, 1, 1'b0, 1, 4};
    tbl[4] = '{8'h00, 8'h80, 2, 1'b0, 1, 4};
    tbl[5] = '{8'h3C, 8'h81, 0, 1'b0, 6, 24};
    for (int t = 0; t < 6; t++) begin
      do_reset();
      eq.push_back(tbl[t].w0);
      eq.push_back(tbl[t].w1);
      repeat (3) step(0, 8'h00);
      set_exp({tbl[t].w1, tbl[t].w0}, tbl[t].none, tbl[t].cnt);
      run(tbl[t].gmax);
      step(0, 8'h00);
      chk("fwd_count", fwd_cnt, tbl[t].fwd);
      chk("consumed_count", cons_cnt, 2);
      chk("underrun_clear", underrun_out, 0);
    end
    // underrun: no exponent word present when square 0 starts
    do_reset();
    set_exp(16'hFFFE, 1'b0, 15);
    for (int s = 0; s < NSQ; s++)
      for (int k = 0; k < NBLK; k++) begin
        if (s == 0 && k == 2) begin
          eq.push_back(8'hFF);
          eq.push_back(8'hFF);
        end
        step(1, 8'(s * NBLK + k));
        if (s == 0 && k == 1) chk("underrun_set", underrun_out, 1);
      end
    step(0, 8'h00);
    chk("underrun_sticky", underrun_out, 1);
    chk("underrun_fwd", fwd_cnt, 60);
    // reset in the middle of square 7, then a fresh exponentiation
    do_reset();
    eq.push_back(8'h05);
    eq.push_back(8'h80);
    repeat (3) step(0, 8'h00);
    set_exp(16'h8005, 1'b0, 3);
    for (int i = 0; i < 7 * NBLK + 2; i++) step(1, 8'(i));
    do_reset();
    eq.push_back(8'h24);
    eq.push_back(8'h40);
    repeat (3) step(0, 8'h00);
    set_exp(16'h4024, 1'b0, 3);
    run(0);
    step(0, 8'h00);
    chk("after_reset_fwd", fwd_cnt, 12);
    chk("after_reset_consumed", cons_cnt, 2);
    // back-to-back runs with the next run's first word prefetched
    do_reset();
    eq.push_back(8'h05);
    eq.push_back(8'h80);
    eq.push_back(8'h81);
    eq.push_back(8'h02);
    repeat (3) step(0, 8'h00);
    set_exp(16'h8005, 1'b0, 3);
    run(0);
    chk("early_consume", cons_cnt, 3);
    set_exp(16'h0281, 1'b0, 3);
    run(0);
    step(0, 8'h00);
    chk("b2b_fwd", fwd_cnt, 24);
    chk("b2b_consumed", cons_cnt, 4);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/square_exponent_selector.md
Name: square_exponent_selector

Overview:
- Sits directly downstream of the Montgomery squarer stream. It consumes the stream of successive reduced squares r^(2^i) mod N, each delivered as NUM_BLOCKS_PER_SQUARE blocks of REGISTER_SIZE bits, LSB block first.
- Forwards only the squares whose exponent bit i is 1, tagged with first/last markers, to the accumulating Montgomery multiplier that builds r^e mod N.
- Exponent bits arrive as REGISTER_SIZE-bit words through a consume-pulse interface, the same style as the k/N constant feeds.

Parameters:
- REGISTER_SIZE, 32, width of every data block and exponent word.
- BITS_IN_NUM, 2048, exponent length in bits, which is also the number of squares per exponentiation (NUM_SQUARES).
- NUM_BLOCKS_PER_SQUARE, 2*BITS_IN_NUM/REGISTER_SIZE, blocks per incoming square.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- square_block_in  input  REGISTER_SIZE  square data block from the squarer.
- square_valid_in  input  1  block valid. No backpressure: must be accepted every cycle it is high.
- exponent_block_in  input  REGISTER_SIZE  next exponent word, LSB is the lowest-index bit.
- exponent_valid_in  input  1  exponent word available.
- consumed_exponent_out  output  1  one-cycle pulse; the word on exponent_block_in was taken this cycle.
- selected_block_out  output  REGISTER_SIZE  forwarded block.
- selected_valid_out  output  1  forwarded block valid.
- selected_first_out  output  1  first block of the first selected square of this exponentiation.
- selected_last_out  output  1  last block of the last selected square.
- done_out  output  1  one-cycle pulse after square NUM_SQUARES-1 completes.
- none_selected_out  output  1  qualifies done_out: the exponent was all zero and nothing was forwarded.
- underrun_out  output  1  sticky; a square started with no exponent word loaded.

Behaviour:
- Reset: every output is 0. Counters, the exponent buffer and all flags are cleared. Reset mid-stream aborts the current exponentiation; no partial done_out is produced.
- Counters:
  - block_ctr counts 0..NUM_BLOCKS_PER_SQUARE-1 and advances on square_valid_in.
  - square_ctr counts 0..NUM_SQUARES-1 and advances when block_ctr wraps.
  - bit_idx = square_ctr mod REGISTER_SIZE.
- Exponent buffer: 2 entries, cur and nxt.
  - Load rule: if an entry is empty and exponent_valid_in=1, load it and pulse consumed_exponent_out in the same cycle. Fill cur first, else nxt.
  - Advance rule: on the last block of the square with bit_idx=REGISTER_SIZE-1, cur is retired; nxt moves into cur, or cur becomes empty.
  - Retire and load in the same cycle are legal. The incoming word lands in cur if nxt was empty, otherwise in nxt.
- Selection:
  - At block_ctr=0, sel = cur[bit_idx]; sel is held for the whole square.
  - If cur is empty at block_ctr=0: underrun_out is set (sticky until reset) and sel=0.
- Output latency is 1 cycle (registered). selected_block_out and selected_valid_out = square_block_in and (square_valid_in & sel), both delayed one cycle.
- selected_first_out is high on the first forwarded block of an exponentiation (internal flag any_sel=0 at that point).
- selected_last_out requires lookahead:
  - On the last block of a selected square, assert it when no higher bit of the exponent is 1.
  - Track this with a remaining-ones check over cur/nxt plus the unread words; in practice compute "no higher set bit in cur above bit_idx and nxt empty-or-zero".
  - Because exponent words are not all buffered, the last word must be loaded before its first square. The bench must supply words ahead of time.
- done_out pulses on the cycle after the last block of square NUM_SQUARES-1.
  - none_selected_out = ~any_sel in that same cycle.
  - Then all counters and any_sel clear, the buffer keeps any prefetched word, and the block is ready for the next exponentiation with no idle cycle.
- Gaps in square_valid_in are allowed anywhere; counters hold during gaps.
- An exponent word arriving while both entries are full is not consumed (no pulse).

Optional Feature:
- SQUARE_SELECTOR_COUNT_EN:
  - Defined: adds output selected_count_out, width $clog2(BITS_IN_NUM+1). It counts selected squares, increments at each selected square's last block, holds its value through the done_out cycle, and clears on the following cycle or on reset.
  - Undefined: the port and counter are absent and all other behaviour is identical.

Decomposition:
- Shared package exp_stream_pkg holds:
  - Localparams NUM_BLOCKS_PER_SQUARE and NUM_SQUARES.
  - Counter widths via $clog2.
  - Typedef block_t = logic[REGISTER_SIZE-1:0].
- One sub-module, exponent_word_buffer: the 2-entry cur/nxt buffer with load/retire, consume pulse and empty flags.

Test Plan (REGISTER_SIZE=8, BITS_IN_NUM=16, so 4 blocks/square, 16 squares, 2 exponent words):
- Exponent words 0x05, 0x80 preloaded; squares streamed back-to-back with blocks 0x00..0x3F.
  - Only squares 0, 2 and 15 are forwarded, 12 blocks in total.
  - first on block 0x00; last on block 0x3F; done_out 1 cycle after the 0x3F input; none_selected_out=0.
- Exponent 0x00, 0x00 -> no selected_valid_out; done_out=1 with none_selected_out=1.
- Words 0xFF, 0xFF; random 0-3 cycle gaps in square_valid_in -> all 64 blocks forwarded, in order, each 1 cycle after input; count=16 when the feature is enabled.
- exponent_valid_in held low until square 1 -> underrun_out=1 from square 0's first block and stays set; square 0 is not forwarded.
- rst_in at square 7, block 2, then a fresh exponentiation -> no done_out for the aborted run; new run correct; consumed_exponent_out pulses exactly twice.
- Two exponentiations back-to-back, with the second run's first word offered during the first run -> the word is loaded into nxt and consumed early; the second run starts the cycle after done_out with correct selection.
